// File: rtl/check_display.sv
// Status display for the adder self-check harness: multiplexes the live vector,
// PASS banner or latched first failure onto an 8-digit seven-segment display.
module check_display #(
  parameter int unsigned SCAN_DIV    = 16384,
  parameter int unsigned BLINK_SCANS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       done,
  input  logic       fail_ripple,
  input  logic       fail_ahead,
  input  logic [8:0] vec,
  input  logic [4:0] exp_sum,
  input  logic [4:0] got_ripple,
  input  logic [4:0] got_ahead,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       led_pass,
  output logic       led_fail
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned RW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_P     = 7'h0C;
  localparam logic [6:0] G_A     = 7'h08;
  localparam logic [6:0] G_S     = 7'h12;
  localparam logic [6:0] G_R     = 7'h2F;

  typedef enum logic [1:0] {RUN, PASS, FAIL} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] scan_cnt;
  logic [2:0]    digit;
  logic [RW-1:0] round_cnt;
  logic          blink;
  logic [8:0]    cap_vec;
  logic [4:0]    cap_exp, cap_got;
  logic          cap_rip;
  logic          scan_wrap, round_wrap, enter_fail;
  logic [7:0]    an_nx;
  logic [6:0]    seg_nx;
  logic          dp_nx;

  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  assign scan_wrap  = (scan_cnt == SW'(SCAN_DIV - 1));
  assign round_wrap = scan_wrap && (digit == 3'd7);
  assign enter_fail = (state == RUN) && (fail_ripple || fail_ahead);

  always_comb begin
    state_nx = state;
    if (state == RUN) begin
      if (fail_ripple || fail_ahead) state_nx = FAIL;
      else if (done)                 state_nx = PASS;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      digit    <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      digit    <= digit + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Round counting starts at FAIL entry so the first blink phase is lit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round_cnt <= '0;
      blink     <= 1'b0;
    end else if (enter_fail) begin
      round_cnt <= '0;
      blink     <= 1'b1;
    end else if ((state == FAIL) && round_wrap) begin
      if (round_cnt == RW'(BLINK_SCANS - 1)) begin
        round_cnt <= '0;
        blink     <= ~blink;
      end else begin
        round_cnt <= round_cnt + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_vec <= '0;
      cap_exp <= '0;
      cap_got <= '0;
      cap_rip <= 1'b0;
    end else if (enter_fail) begin
      cap_vec <= vec;
      cap_exp <= exp_sum;
      cap_got <= fail_ripple ? got_ripple : got_ahead;
      cap_rip <= fail_ripple;
    end
  end

  always_comb begin
    an_nx  = ~(8'b1 << digit);
    seg_nx = G_BLANK;
    dp_nx  = 1'b1;
    case (state)
      RUN: begin
        case (digit)
          3'd7: seg_nx = hex_glyph({3'b000, vec[8]});
          3'd6: seg_nx = hex_glyph(vec[7:4]);
          3'd5: seg_nx = hex_glyph(vec[3:0]);
          default: seg_nx = G_BLANK;
        endcase
      end
      PASS: begin
        case (digit)
          3'd7: seg_nx = G_P;
          3'd6: seg_nx = G_A;
          3'd5: seg_nx = G_S;
          3'd4: seg_nx = G_S;
          default: seg_nx = G_BLANK;
        endcase
      end
      FAIL: begin
        dp_nx = (digit != 3'd5);
        case (digit)
          3'd7: seg_nx = hex_glyph({3'b000, cap_vec[8]});
          3'd6: seg_nx = hex_glyph(cap_vec[7:4]);
          3'd5: seg_nx = hex_glyph(cap_vec[3:0]);
          3'd4: seg_nx = hex_glyph({3'b000, cap_exp[4]});
          3'd3: seg_nx = hex_glyph(cap_exp[3:0]);
          3'd2: seg_nx = hex_glyph({3'b000, cap_got[4]});
          3'd1: seg_nx = hex_glyph(cap_got[3:0]);
          default: seg_nx = cap_rip ? G_R : G_A;
        endcase
      end
      default: seg_nx = G_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an       <= '1;
      seg      <= G_BLANK;
      dp       <= 1'b1;
      led_pass <= 1'b0;
      led_fail <= 1'b0;
    end else begin
      an       <= an_nx;
      seg      <= seg_nx;
      dp       <= dp_nx;
      led_pass <= (state == PASS);
      led_fail <= (state == FAIL) && blink;
    end
  end

endmodule

// File: tb/tb_check_display.sv
// Bench for check_display: table of display snapshots, random sweeps against a
// cycle-count based reference model, plus blink and asynchronous reset sequences.
module tb_check_display;

  localparam int S     = 4;
  localparam int B     = 2;
  localparam int ROUND = 8 * S;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       done = 1'b0, fail_ripple = 1'b0, fail_ahead = 1'b0;
  logic [8:0] vec = '0;
  logic [4:0] exp_sum = '0, got_ripple = '0, got_ahead = '0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp, led_pass, led_fail;

  int total = 0;
  int bad   = 0;

  check_display #(.SCAN_DIV(S), .BLINK_SCANS(B)) dut (
    .clk(clk), .reset(reset), .done(done),
    .fail_ripple(fail_ripple), .fail_ahead(fail_ahead),
    .vec(vec), .exp_sum(exp_sum), .got_ripple(got_ripple), .got_ahead(got_ahead),
    .an(an), .seg(seg), .dp(dp), .led_pass(led_pass), .led_fail(led_fail)
  );

  always #5 clk = ~clk;

  // character codes: 0..15 hex, 16 'P', 17 'S', 18 'r', 19 blank
  function automatic logic [6:0] glyph(input int c);
    case (c)
      0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
      4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
      8: return 7'h00;   9: return 7'h10;   10: return 7'h08;  11: return 7'h03;
      12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
      16: return 7'h0C;  17: return 7'h12;  18: return 7'h2F;
      default: return 7'h7F;
    endcase
  endfunction

  // st: 0 RUN, 1 PASS, 2 FAIL
  function automatic logic [6:0] model_seg(input int st, input int d, input logic [8:0] v,
                                           input logic [8:0] cv, input logic [4:0] ce,
                                           input logic [4:0] cg, input logic cr);
    int ch[8];
    for (int i = 0; i < 8; i++) ch[i] = 19;
    if (st == 0) begin
      ch[7] = int'(v[8]); ch[6] = int'(v[7:4]); ch[5] = int'(v[3:0]);
    end else if (st == 1) begin
      ch[7] = 16; ch[6] = 10; ch[5] = 17; ch[4] = 17;
    end else begin
      ch[7] = int'(cv[8]); ch[6] = int'(cv[7:4]); ch[5] = int'(cv[3:0]);
      ch[4] = int'(ce[4]); ch[3] = int'(ce[3:0]);
      ch[2] = int'(cg[4]); ch[1] = int'(cg[3:0]);
      ch[0] = cr ? 18 : 10;
    end
    return glyph(ch[d]);
  endfunction

  // Blink phase ahead of edge e, FAIL entered on edge ee: count completed rounds since.
  function automatic logic model_blink(input int e, input int ee);
    int w;
    w = e / ROUND - (ee + 1) / ROUND;
    return ((w / B) % 2) == 0;
  endfunction

  int         m_k = 0, m_state = 0, m_ee = 0;
  logic [8:0] m_vec = '0;
  logic [4:0] m_exp = '0, m_got = '0;
  logic       m_rip = 1'b0;
  logic [7:0] x_an = 8'hFF;
  logic [6:0] x_seg = 7'h7F;
  logic       x_dp = 1'b1, x_lp = 1'b0, x_lf = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_k <= 0; m_state <= 0; m_ee <= 0;
      m_vec <= '0; m_exp <= '0; m_got <= '0; m_rip <= 1'b0;
      x_an <= 8'hFF; x_seg <= 7'h7F; x_dp <= 1'b1; x_lp <= 1'b0; x_lf <= 1'b0;
    end else begin
      x_an  <= ~(8'b1 << ((m_k / S) % 8));
      x_seg <= model_seg(m_state, (m_k / S) % 8, vec, m_vec, m_exp, m_got, m_rip);
      x_dp  <= !((m_state == 2) && (((m_k / S) % 8) == 5));
      x_lp  <= (m_state == 1);
      x_lf  <= (m_state == 2) && model_blink(m_k, m_ee);
      m_k   <= m_k + 1;
      if (m_state == 0) begin
        if (fail_ripple || fail_ahead) begin
          m_state <= 2; m_ee <= m_k;
          m_vec <= vec; m_exp <= exp_sum; m_rip <= fail_ripple;
          m_got <= fail_ripple ? got_ripple : got_ahead;
        end else if (done) begin
          m_state <= 1;
        end
      end
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if ({an, seg, dp, led_pass, led_fail} !== {x_an, x_seg, x_dp, x_lp, x_lf}) begin
        bad++;
        if (bad <= 20)
          $display("FAIL model_cycle t=%0t got an=%h seg=%h dp=%b lp=%b lf=%b want an=%h seg=%h dp=%b lp=%b lf=%b",
                   $time, an, seg, dp, led_pass, led_fail, x_an, x_seg, x_dp, x_lp, x_lf);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic zero_inputs();
    done = 0; fail_ripple = 0; fail_ahead = 0;
    vec = '0; exp_sum = '0; got_ripple = '0; got_ahead = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    zero_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic scramble(input bit with_ctrl);
    vec = 9'($urandom); exp_sum = 5'($urandom);
    got_ripple = 5'($urandom); got_ahead = 5'($urandom);
    if (with_ctrl) begin
      fail_ripple = 1'($urandom); fail_ahead = 1'($urandom); done = 1'($urandom);
    end
  endtask

  typedef struct {
    logic [8:0]      v;
    logic            fr, fa, dn;
    logic [4:0]      e, gr, ga;
    logic            scr;
    logic [7:0][6:0] g;
    logic            lp;
    logic            is_fail;
  } rec_t;

  rec_t tv[7];

  initial begin
    tv[0] = '{v:9'h000, fr:0, fa:0, dn:0, e:5'h00, gr:5'h00, ga:5'h00, scr:0,
              g:{7'h40,7'h40,7'h40,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F}, lp:0, is_fail:0};
    tv[1] = '{v:9'h1A5, fr:0, fa:1, dn:0, e:5'h10, gr:5'h1F, ga:5'h00, scr:1,
              g:{7'h79,7'h08,7'h12,7'h79,7'h40,7'h40,7'h40,7'h08}, lp:0, is_fail:1};
    tv[2] = '{v:9'h03C, fr:1, fa:1, dn:0, e:5'h12, gr:5'h03, ga:5'h07, scr:1,
              g:{7'h40,7'h30,7'h46,7'h79,7'h24,7'h40,7'h30,7'h2F}, lp:0, is_fail:1};
    tv[3] = '{v:9'h100, fr:1, fa:0, dn:1, e:5'h0F, gr:5'h1E, ga:5'h00, scr:1,
              g:{7'h79,7'h40,7'h40,7'h40,7'h0E,7'h79,7'h06,7'h2F}, lp:0, is_fail:1};
    tv[4] = '{v:9'h155, fr:0, fa:0, dn:1, e:5'h00, gr:5'h00, ga:5'h00, scr:1,
              g:{7'h0C,7'h08,7'h12,7'h12,7'h7F,7'h7F,7'h7F,7'h7F}, lp:1, is_fail:0};
    tv[5] = '{v:9'h0B9, fr:1, fa:0, dn:0, e:5'h14, gr:5'h0D, ga:5'h02, scr:1,
              g:{7'h40,7'h03,7'h10,7'h79,7'h19,7'h40,7'h21,7'h2F}, lp:0, is_fail:1};
    tv[6] = '{v:9'h1FF, fr:0, fa:1, dn:0, e:5'h1E, gr:5'h05, ga:5'h1C, scr:1,
              g:{7'h79,7'h0E,7'h0E,7'h79,7'h06,7'h79,7'h46,7'h08}, lp:0, is_fail:1};

    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {an, seg, dp, led_pass, led_fail}, {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
    reset = 1'b0;
    #1 check("an_after_release", an, 8'hFF);
    @(negedge clk);
    check("an_first_digit", an, 8'hFE);

    for (int r = 0; r < 7; r++) begin
      logic [6:0] seen_seg[8];
      logic       seen_dp[8];
      bit         seen[8];
      do_reset();
      repeat (3) @(negedge clk);
      vec = tv[r].v; fail_ripple = tv[r].fr; fail_ahead = tv[r].fa; done = tv[r].dn;
      exp_sum = tv[r].e; got_ripple = tv[r].gr; got_ahead = tv[r].ga;
      @(negedge clk);
      if (tv[r].scr) scramble(1'b1);
      @(negedge clk);
      for (int i = 0; i < 8; i++) seen[i] = 0;
      for (int c = 0; c < ROUND; c++) begin
        int d;
        d = -1;
        for (int i = 0; i < 8; i++) if (an === ~(8'b1 << i)) d = i;
        if (d < 0) check($sformatf("rec%0d_an_onehot", r), an, 8'h00);
        else begin seen[d] = 1; seen_seg[d] = seg; seen_dp[d] = dp; end
        @(negedge clk);
        if (tv[r].scr) scramble(1'b1);
      end
      for (int i = 0; i < 8; i++) begin
        if (!seen[i]) check($sformatf("rec%0d_digit%0d_seen", r, i), 0, 1);
        else begin
          check($sformatf("rec%0d_seg%0d", r, i), seen_seg[i], tv[r].g[i]);
          check($sformatf("rec%0d_dp%0d", r, i), seen_dp[i], !(tv[r].is_fail && i == 5));
        end
      end
      check($sformatf("rec%0d_led_pass", r), led_pass, tv[r].lp);
      check($sformatf("rec%0d_led_fail", r), led_fail, tv[r].is_fail);
      zero_inputs();
    end

    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        scramble(1'b0);
        fail_ripple = ($urandom_range(0, 59) == 0);
        fail_ahead  = ($urandom_range(0, 59) == 0);
        done        = ($urandom_range(0, 89) == 0);
      end
      zero_inputs();
    end

    begin
      int   last_t, ntog;
      logic prev;
      do_reset();
      repeat (5) @(negedge clk);
      vec = 9'h0A3; exp_sum = 5'h0D; got_ahead = 5'h0C; fail_ahead = 1'b1;
      @(negedge clk);
      fail_ahead = 1'b0;
      @(negedge clk);
      check("blink_entry", led_fail, 1'b1);
      prev = led_fail; ntog = 0; last_t = -1;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (led_fail !== prev) begin
          if (last_t >= 0) check("blink_period", c - last_t, 2 * ROUND);
          last_t = c; ntog++; prev = led_fail;
        end
      end
      check("blink_toggles", ntog >= 3, 1);
    end

    repeat (S + 1) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset", {an, seg, dp, led_pass, led_fail}, {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    #1 check("an_after_release2", an, 8'hFF);
    @(negedge clk);
    check("an_first_digit2", an, 8'hFE);
    check("seg_first_digit2", seg, 7'h7F);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/check_display.md
# check_display

Downstream status stage for the adder self-check harness: consumes the per-vector compare results (reference vs. ripple-carry vs. carry-lookahead) and the sweep-done flag, and presents them on the 8-digit multiplexed seven-segment display plus two LEDs. It latches the first failing vector and its expected and actual sums, so a failure stays readable after the sweep freezes. It sits between the stimulus/compare logic and the board pins.

## Interface
- SCAN_DIV, 16384: clk cycles per digit slot; must be ≥ 2.
- BLINK_SCANS, 64: full 8-digit scan rounds per fail-LED blink phase; must be ≥ 1.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- done  in  1  level; sweep finished with no mismatch
- fail_ripple  in  1  level; ripple adder mismatch on current vector
- fail_ahead  in  1  level; lookahead adder mismatch on current vector
- vec  in  9  current vector {cin, b[3:0], a[3:0]}
- exp_sum  in  5  reference {cout, sum[3:0]}
- got_ripple  in  5  ripple adder {cout, sum}
- got_ahead  in  5  lookahead adder {cout, sum}
- an  out  8  digit enables, active-low; an[i] selects digit i (7 = leftmost)
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- led_pass  out  1  sweep passed
- led_fail  out  1  failure latched (blinking)

## Operation
- States: RUN (reset), PASS, FAIL. PASS and FAIL are terminal; only reset leaves them.
- RUN → FAIL when fail_ripple | fail_ahead is sampled high. FAIL takes priority over done on the same cycle.
- RUN → PASS when done is high and no fail is high.
- On entering FAIL, capture vec, exp_sum, and the failing adder: ripple if fail_ripple, else lookahead; ripple wins when both are high. Also capture that adder's got_* value. The captured values never change again until reset.
- Digit content, digit 7..0:
  - RUN: live vec as 3 hex digits on digits 7..5 (digit 7 = {3'b0, vec[8]}); digits 4..0 blank.
  - PASS: digits 7..4 show "PASS"; the rest are blank.
  - FAIL: digits 7..5 show the captured vec, digits 4..3 the captured exp, digits 2..1 the captured got (upper digit = {3'b0, bit4}). Digit 0 shows 'r' (ripple) or 'A' (ahead).
- Hex glyphs (active-low gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - P=0C, S=12, r=2F, blank=7F.
- dp: low only on digit 5 in FAIL, marking the vec/exp boundary; high otherwise.
- led_pass = 1 in PASS only.
- led_fail: in FAIL, follows a blink phase that is set to 1 on FAIL entry and toggles every BLINK_SCANS completed rounds. It is 0 in RUN and PASS.

## Timing
- Scan counter counts 0..SCAN_DIV-1 and wraps. The digit index advances 0→1→…→7→0 on each wrap. A round completes when the index wraps 7→0.
- an, seg, dp, led_* are registered, so outputs reflect the state and digit index of the previous cycle (1-cycle latency).
- A state transition is visible on led_pass/led_fail on the cycle after the sampling edge. The displayed glyph changes on that same cycle for the currently active digit.
- Capture registers load on the same edge as the RUN→FAIL transition.
- Reset (asynchronous, any time, including mid-scan or in FAIL) sets:
  - an=FF, seg=7F, dp=1, led_pass=0, led_fail=0
  - state RUN, digit index 0, scan counter 0, round counter 0, blink phase 0, captures 0.
- First cycle after reset release: an=FF still. Next cycle: an=FE (digit 0) is driven.
- Exactly one an bit is low at any time after that point.
- The scan continues in every state, and inputs are ignored in PASS/FAIL.

## Test plan
- SCAN_DIV=4. Reset, release, hold vec=9'h000 with fails/done low. Required: an walks FE, FD, FB, …, 7F, each held 4 cycles. Digits 7..5 show 40; other digits show 7F. led_*=0.
- vec=9'h1A5, then fail_ahead=1 for one cycle with exp=5'h10, got_ahead=5'h00. Required:
  - FAIL entered; digits 7..0 = 1,A,5,1,0,0,0,'A' (79,08,12,79,40,40,40,08).
  - dp low on digit 5; led_fail=1.
  - The display is unchanged after the inputs change.
- fail_ripple and fail_ahead both high, with got_ripple=5'h03 and got_ahead=5'h07. Required: digit 0 = 'r' (2F); digits 2..1 = 0,3.
- done and fail_ripple high on the same cycle. Required: FAIL, not PASS; led_pass stays 0.
- done=1 alone. Required: PASS; digits 7..4 = 0C,08,12,12; led_pass=1; a later fail input is ignored.
- BLINK_SCANS=2, in FAIL. Required: led_fail toggles every 64 cycles. Asserting reset mid-digit sets all outputs to reset values immediately, with no clock edge needed.
